// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Change in busy population for one bit; a same-edge set beats a clear.
  function automatic logic signed [1:0] popcount_delta(input logic set,
                                                       input logic clr,
                                                       input logic was_busy);
    if (set && !was_busy) return 2'sd1;
    if (!set && clr && was_busy) return -2'sd1;
    return 2'sd0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// Busy bit per register with set-over-clear priority and a registered busy popcount.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busyNext;
  logic signed [2:0] countAdj;

  always_comb begin
    busyNext = busy;
    countAdj = 3'sd0;
    for (int j = 0; j < DEPTH; j++) begin
      logic setBit;
      logic clrBit;
      logic signed [1:0] d;
      setBit = issue_en && (issue_addr == ADDR_W'(j));
      clrBit = clr_en && (clr_addr == ADDR_W'(j));
      busyNext[j] = setBit | (busy[j] & ~clrBit);
      d = popcount_delta(setBit, clrBit, busy[j]);
      countAdj = countAdj + {d[1], d};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy <= busyNext;
      if (countAdj > 3'sd0)
        busy_count <= busy_count + {{ADDR_W{1'b0}}, 1'b1};
      else if (countAdj < 3'sd0)
        busy_count <= busy_count - {{ADDR_W{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-first bypass, optional zero register and busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  output logic [ADDR_W:0]         busy_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wrEff;
  logic              issueEff;

  // Register 0 must never hold data or a producer when it is hardwired.
  assign wrEff    = wr_en    && !((ZERO_REG != 0) && (wr_addr == ZA));
  assign issueEff = issue_en && !((ZERO_REG != 0) && (issue_addr == ZA));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else if (wrEff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  busy_scoreboard #(.ADDR_W(ADDR_W)) uBusy (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issueEff),
    .issue_addr (issue_addr),
    .clr_en     (wrEff),
    .clr_addr   (wr_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  for (genvar i = 0; i < NREAD; i++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit  = wrEff && (wr_addr == addr);

    always_comb begin
      if (rst || ((ZERO_REG != 0) && (addr == ZA)))
        rd_data[i*DATA_W +: DATA_W] = '0;
      else if (hit)
        rd_data[i*DATA_W +: DATA_W] = wr_data;
      else
        rd_data[i*DATA_W +: DATA_W] = regs[addr];
    end

    // A register being written this cycle is already satisfied by the bypass.
    assign rd_busy[i] = !rst && busy[addr] && !hit;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: expected read results are queued on drive and compared at the next sample point.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [5:0]  busy_count;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0, d1;
    logic        b0, b1;
    logic [5:0]  cnt;
  } expT;

  expT         expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mRegs [32];
  bit          mBusy [32];
  logic [31:0] sD0, sD1;
  logic        sB0, sB1;
  logic [5:0]  sCnt;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return mRegs[a];
  endfunction

  function automatic logic modelBusy(input logic [4:0] a);
    if (rst) return 1'b0;
    return mBusy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic logic [5:0] modelCount();
    int n = 0;
    for (int k = 0; k < 32; k++) n += int'(mBusy[k]);
    return 6'(n);
  endfunction

  task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit ie, input logic [4:0] ia, input logic [4:0] a0, input logic [4:0] a1);
    expT e;
    expT g;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia; rd_addr = {a1, a0};
    e.d0 = modelRead(a0); e.d1 = modelRead(a1);
    e.b0 = modelBusy(a0); e.b1 = modelBusy(a1);
    e.cnt = modelCount();
    expQ.push_back(e);
    @(negedge clk);
    sD0 = rd_data[31:0]; sD1 = rd_data[63:32];
    sB0 = rd_busy[0];    sB1 = rd_busy[1];
    sCnt = busy_count;
    if (expQ.size() == 0) begin
      checkVal("queue_empty", 32'd1, 32'd0);
    end else begin
      g = expQ.pop_front();
      checkVal("rd_data0", sD0, g.d0);
      checkVal("rd_data1", sD1, g.d1);
      checkVal("rd_busy0", {31'd0, sB0}, {31'd0, g.b0});
      checkVal("rd_busy1", {31'd0, sB1}, {31'd0, g.b1});
      checkVal("busy_count", {26'd0, sCnt}, {26'd0, g.cnt});
    end
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 32; k++) begin mRegs[k] = 32'd0; mBusy[k] = 1'b0; end
    end else begin
      if (we && wa != 5'd0) begin mRegs[wa] = wd; mBusy[wa] = 1'b0; end
      if (ie && ia != 5'd0) mBusy[ia] = 1'b1;
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin mRegs[k] = 32'd0; mBusy[k] = 1'b0; end
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; rd_addr = '0;
    @(posedge clk); #1;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 2);
    for (int a = 0; a < 32; a++) step(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
    checkVal("reset_count", {26'd0, sCnt}, 32'd0);

    step(0, 1, 2, 32'd128, 0, 0, 2, 0);
    checkVal("bypass_r2", sD0, 32'd128);
    step(0, 0, 0, 0, 0, 0, 2, 2);
    checkVal("array_r2", sD0, 32'd128);

    step(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    checkVal("r0_same", sD0, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("r0_after", sD0, 32'd0);

    step(0, 0, 0, 0, 1, 5, 5, 7);
    step(0, 0, 0, 0, 1, 7, 5, 7);
    checkVal("count_1", {26'd0, sCnt}, 32'd1);
    checkVal("busy_r5", {31'd0, sB0}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 5, 7);
    checkVal("count_2", {26'd0, sCnt}, 32'd2);
    step(0, 1, 5, 32'd42, 0, 0, 5, 7);
    checkVal("wb_busy_r5", {31'd0, sB0}, 32'd0);
    checkVal("wb_data_r5", sD0, 32'd42);
    step(0, 0, 0, 0, 0, 0, 5, 7);
    checkVal("count_after_wb", {26'd0, sCnt}, 32'd1);

    step(0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    checkVal("count_r9_busy", {26'd0, sCnt}, 32'd2);
    step(0, 1, 9, 32'h0000_0099, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    checkVal("r9_still_busy", {31'd0, sB0}, 32'd1);
    checkVal("r9_count_same", {26'd0, sCnt}, 32'd2);
    checkVal("r9_data", sD0, 32'h0000_0099);

    step(0, 0, 0, 0, 1, 3, 3, 4);
    step(1, 1, 4, 32'h44, 1, 6, 3, 4);
    step(0, 0, 0, 0, 0, 0, 3, 4);
    checkVal("rst_count", {26'd0, sCnt}, 32'd0);
    checkVal("rst_r3", sD0, 32'd0);
    checkVal("rst_r4", sD1, 32'd0);

    for (int a = 0; a < 32; a++) step(0, 0, 0, 0, 1, 5'(a), 0, 5'(a));
    step(0, 0, 0, 0, 1, 0, 0, 31);
    checkVal("count_max", {26'd0, sCnt}, 32'd31);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    checkVal("count_max_hold", {26'd0, sCnt}, 32'd31);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom), $urandom,
           1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the MIPS32 register file. It provides NREAD combinational read ports, write-to-read bypass, a hardwired zero register and an integrated busy-bit scoreboard that tracks registers with an outstanding producer, such as a pending load. It sits between decode (reads, issue marking) and writeback (writes, busy clearing) in the pipelined core.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports, 1..4
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and issues

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NREAD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, combinational, packed the same way
- rd_busy  out  NREAD  register has an outstanding producer
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- issue_en  in  1  mark issue_addr busy
- issue_addr  in  ADDR_W  register to mark busy
- busy_count  out  ADDR_W+1  number of busy registers

## Operation
- Storage: 2**ADDR_W x DATA_W flops. Write occurs at the clk edge when wr_en=1 and rst=0.
- Read is combinational: rd_data[i] = regs[rd_addr[i]].
- Bypass (write-first): when wr_en=1 and wr_addr==rd_addr[i], rd_data[i]=wr_data in the same cycle.
- Zero register (ZERO_REG=1):
  - A write to address 0 is dropped.
  - Reads of address 0 return 0, with no bypass.
  - rd_busy for address 0 is always 0.
- Scoreboard: one busy bit per register.
  - issue_en sets busy[issue_addr] at the edge.
  - wr_en clears busy[wr_addr] at the edge.
- Same-edge issue_en and wr_en:
  - Different addresses: both take effect.
  - Same address: the bit ends set, because the new producer wins.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (wr_en AND wr_addr==rd_addr[i]). Data being bypassed is never reported busy.
- A write to a non-busy register is legal (ALU results) and leaves its busy bit clear.
- Issue of an already-busy register is legal; the bit stays set.
- busy_count is a registered popcount:
  - Updated at each edge by +1 (bit set, previously clear), -1 (bit cleared), or 0.
  - It always equals the number of set busy bits. It never wraps; its maximum is 2**ADDR_W - 1 with ZERO_REG=1.

## Timing
- Reset is synchronous. At the first clk edge with rst=1:
  - All registers cleared to 0.
  - All busy bits cleared; busy_count = 0.
- While rst=1: rd_data = 0, rd_busy = 0, and wr_en and issue_en are ignored.
- Reset mid-operation discards pending writes and issues in that cycle. No partial state survives.
- Read latency is 0 cycles (combinational from array or bypass).
- Write visibility:
  - Same cycle via bypass.
  - From the next cycle via the array.
- Busy set by issue at edge N is visible on rd_busy from cycle N+1.
- Busy clear is visible in the writeback cycle itself (via bypass masking) and from the array after the edge.
- No handshakes and no backpressure. Stall decisions belong to the hazard unit, which consumes rd_busy.

## Structure
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W defaults
  - ZERO_ADDR constant (0)
  - function popcount_delta(set, clr, was_busy) returning a signed 2-bit adjustment
- Sub-module busy_scoreboard: busy bit vector, set/clear priority logic, and the busy_count counter; ports clk, rst, issue_en/addr, clr_en/addr, busy vector out, busy_count.
- The top level holds the data array, read muxes and bypass.

## Test plan
- Reset, then read all addresses on both ports -> every rd_data = 0, rd_busy = 0, busy_count = 0.
- Write 128 to r2 while rd_addr[0]=2 in the same cycle -> rd_data[0] = 128 that cycle (bypass); on the next cycle with wr_en=0 -> still 128.
- Write 0xDEADBEEF to r0 with ZERO_REG=1 -> reading r0 returns 0 both in that cycle and afterwards.
- Issue r5 and r7 on consecutive cycles:
  - busy_count goes 1 then 2, and rd_busy for r5 = 1.
  - Write r5 = 42 -> rd_busy = 0 and rd_data = 42 in the same cycle; busy_count = 1 after the edge.
- Same-edge issue_en and wr_en to r9 (r9 busy beforehand) -> r9 stays busy, busy_count is unchanged, and r9 holds wr_data.
- Assert rst while r3 is busy and a write to r4 is pending -> after the edge, busy_count = 0 and r3 = r4 = 0.
